// File: rtl/moore_counter_fsm_if.sv
// Button/LED signal bundle for moore_counter_fsm.
// master drives the buttons and switches; slave (the counter) drives the LEDs.
interface moore_counter_fsm_if #(
   parameter int unsigned CNT_WIDTH = 4
) ();
   logic                 go_btn;
   logic                 pause_btn;
   logic                 dir;
   logic                 loop_en;
   logic [CNT_WIDTH-1:0] count;
   logic                 done_sig;
   logic                 busy;

   modport master (
      output go_btn, pause_btn, dir, loop_en,
      input  count, done_sig, busy
   );

   modport slave (
      input  go_btn, pause_btn, dir, loop_en,
      output count, done_sig, busy
   );
endinterface

// File: rtl/moore_counter_fsm.sv
// Tick-driven Moore counter: start on go, count up or down to a terminal value,
// optional pause, hold DONE for DONE_TICKS ticks, then idle or auto-repeat.
module moore_counter_fsm #(
   parameter int unsigned CNT_WIDTH  = 4,
   parameter int unsigned COUNT_MAX  = 15,
   parameter int unsigned TICK_DIV   = 1500000,
   parameter int unsigned DONE_TICKS = 1
) (
   input logic                clk,
   input logic                rst_btn,
   moore_counter_fsm_if.slave bus
);
   localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned DONE_W = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;
   localparam logic [TICK_W-1:0]    TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [DONE_W-1:0]    DONE_LAST = DONE_W'(DONE_TICKS - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_TOP   = CNT_WIDTH'(COUNT_MAX);

   typedef enum logic [1:0] {StIdle, StCounting, StPaused, StDone} state_e;

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
   logic [DONE_W-1:0]    done_cnt_q, done_cnt_d;
   logic                 go_prev_q;
   logic                 go_pending_q, go_pending_d;
   logic                 dir_q, dir_d;

   logic                 go, press, pause, tick;
   logic [CNT_WIDTH-1:0] start_val, term_val;

   assign go         = ~bus.go_btn;
   assign press      = go & ~go_prev_q;
   assign pause      = ~bus.pause_btn;
   assign tick       = (tick_cnt_q == TICK_LAST);
   assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
   assign start_val  = dir_q ? CNT_TOP : '0;
   assign term_val   = dir_q ? '0 : CNT_TOP;

   // A press between ticks is remembered until the next tick; the tick itself
   // always clears it, and IDLE also looks at a press landing on the tick.
   always_comb begin
      go_pending_d = go_pending_q;
      if (tick) begin
         go_pending_d = 1'b0;
      end else if (press && (state_q == StIdle)) begin
         go_pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_btn) begin
         state_q      <= StIdle;
         count_q      <= '0;
         tick_cnt_q   <= '0;
         done_cnt_q   <= '0;
         go_prev_q    <= 1'b0;
         go_pending_q <= 1'b0;
         dir_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         tick_cnt_q   <= tick_cnt_d;
         done_cnt_q   <= done_cnt_d;
         go_prev_q    <= go;
         go_pending_q <= go_pending_d;
         dir_q        <= dir_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      done_cnt_d = done_cnt_q;
      dir_d      = dir_q;
      if (tick) begin
         case (state_q)
            StIdle: begin
               count_d = '0;
               if (go_pending_q || press) begin
                  dir_d   = bus.dir;
                  count_d = bus.dir ? CNT_TOP : '0;
                  state_d = StCounting;
               end
            end
            StCounting: begin
               if (pause) begin
                  state_d = StPaused;
               end else if (count_q == term_val) begin
                  state_d    = StDone;
                  done_cnt_d = '0;
               end else begin
                  count_d = dir_q ? count_q - 1'b1 : count_q + 1'b1;
               end
            end
            StPaused: begin
               if (!pause) begin
                  state_d = StCounting;
               end
            end
            StDone: begin
               if (done_cnt_q == DONE_LAST) begin
                  done_cnt_d = '0;
                  if (bus.loop_en) begin
                     state_d = StCounting;
                     count_d = start_val;
                  end else begin
                     state_d = StIdle;
                     count_d = '0;
                  end
               end else begin
                  done_cnt_d = done_cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = StIdle;
               count_d = '0;
            end
         endcase
      end
   end

   always_comb begin
      bus.count    = count_q;
      bus.done_sig = (state_q == StDone);
      bus.busy     = (state_q == StCounting) || (state_q == StPaused);
   end
endmodule

// File: tb/tb_moore_counter_fsm.sv
// Self-checking bench for moore_counter_fsm with TICK_DIV=4, COUNT_MAX=5, DONE_TICKS=2:
// per-tick vector table plus hand sequences for reset, tick-edge press and mid-run reset.
module tb_moore_counter_fsm;
   localparam int unsigned CW   = 4;
   localparam int unsigned CMAX = 5;
   localparam int unsigned TDIV = 4;
   localparam int unsigned DT   = 2;

   logic clk     = 1'b0;
   logic rst_btn = 1'b0;

   moore_counter_fsm_if #(.CNT_WIDTH(CW)) bus ();

   moore_counter_fsm #(
      .CNT_WIDTH (CW),
      .COUNT_MAX (CMAX),
      .TICK_DIV  (TDIV),
      .DONE_TICKS(DT)
   ) dut (
      .clk    (clk),
      .rst_btn(rst_btn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          pulse_go;
      logic          hold_go;
      logic          pause;
      logic          dir;
      logic          loop_en;
      logic [CW-1:0] exp_count;
      logic          exp_done;
      logic          exp_busy;
      int            exp_done_clks;
   } vec_t;

   typedef struct {
      logic [CW-1:0] count;
      logic          done;
      logic          busy;
   } exp_t;

   vec_t vt[$];
   exp_t sb[$];
   int   nvec      = 0;
   int   nfail     = 0;
   int   done_clks = 0;
   int   row       = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic void add(input logic pg, input logic hg, input logic pz, input logic d,
                               input logic lp, input int c, input logic dn, input logic by,
                               input int dclk);
      vec_t v;
      v.pulse_go      = pg;
      v.hold_go       = hg;
      v.pause         = pz;
      v.dir           = d;
      v.loop_en       = lp;
      v.exp_count     = CW'(c);
      v.exp_done      = dn;
      v.exp_busy      = by;
      v.exp_done_clks = dclk;
      vt.push_back(v);
   endfunction

   // Called just after a tick edge; returns just after the next tick edge.
   task automatic tick_period(input logic pg, input logic hg, input logic pz, input logic d,
                              input logic lp);
      bus.pause_btn = ~pz;
      bus.dir       = d;
      bus.loop_en   = lp;
      bus.go_btn    = ~(pg | hg);
      for (int c = 0; c < int'(TDIV); c++) begin
         @(posedge clk);
         #1;
         if (c == 0 && pg && !hg) bus.go_btn = 1'b1;
         if (bus.done_sig === 1'b1) done_clks++;
      end
   endtask

   task automatic apply(input vec_t v);
      exp_t e;
      sb.push_back('{count: v.exp_count, done: v.exp_done, busy: v.exp_busy});
      tick_period(v.pulse_go, v.hold_go, v.pause, v.dir, v.loop_en);
      if (sb.size() == 0) begin
         check($sformatf("row%0d scoreboard", row), 0, 1);
      end else begin
         e = sb.pop_front();
         check($sformatf("row%0d count", row), 32'(bus.count), 32'(e.count));
         check($sformatf("row%0d done_sig", row), 32'(bus.done_sig), 32'(e.done));
         check($sformatf("row%0d busy", row), 32'(bus.busy), 32'(e.busy));
      end
      if (v.exp_done_clks >= 0) begin
         check($sformatf("row%0d done_clks", row), done_clks, v.exp_done_clks);
         done_clks = 0;
      end
      row++;
   endtask

   initial begin
      bus.go_btn    = 1'b1;
      bus.pause_btn = 1'b1;
      bus.dir       = 1'b0;
      bus.loop_en   = 1'b0;

      // Up run, no loop: 1..5, DONE for two ticks (8 clks), back to IDLE.
      for (int i = 1; i <= int'(CMAX); i++) add(0, 0, 0, 0, 0, i, 0, 1, -1);
      add(0, 0, 0, 0, 0, 5, 1, 0, -1);
      add(0, 0, 0, 0, 0, 5, 1, 0, -1);
      add(0, 0, 0, 0, 0, 0, 0, 0, 8);
      // Down run with loop; dir toggled mid-run, reload uses captured dir.
      add(1, 0, 0, 1, 1, 5, 0, 1, -1);
      add(0, 0, 0, 0, 1, 4, 0, 1, -1);
      add(0, 0, 0, 0, 1, 3, 0, 1, -1);
      add(0, 0, 0, 1, 1, 2, 0, 1, -1);
      add(0, 0, 0, 0, 1, 1, 0, 1, -1);
      add(0, 0, 0, 0, 1, 0, 0, 1, -1);
      add(0, 0, 0, 0, 1, 0, 1, 0, -1);
      add(0, 0, 0, 0, 1, 0, 1, 0, -1);
      add(0, 0, 0, 0, 1, 5, 0, 1, -1);
      add(0, 0, 0, 0, 1, 4, 0, 1, -1);
      add(0, 0, 0, 0, 1, 3, 0, 1, -1);
      add(0, 0, 0, 0, 1, 2, 0, 1, -1);
      add(0, 0, 0, 0, 1, 1, 0, 1, -1);
      add(0, 0, 0, 0, 0, 0, 0, 1, -1);
      add(0, 0, 0, 0, 0, 0, 1, 0, -1);
      add(0, 0, 0, 0, 0, 0, 1, 0, -1);
      add(0, 0, 0, 0, 0, 0, 0, 0, -1);
      // Up run paused at 3 for three ticks; a go press while paused is ignored.
      add(1, 0, 0, 0, 0, 0, 0, 1, -1);
      add(0, 0, 0, 0, 0, 1, 0, 1, -1);
      add(0, 0, 0, 0, 0, 2, 0, 1, -1);
      add(0, 0, 0, 0, 0, 3, 0, 1, -1);
      add(0, 0, 1, 0, 0, 3, 0, 1, -1);
      add(1, 0, 1, 0, 0, 3, 0, 1, -1);
      add(0, 0, 1, 0, 0, 3, 0, 1, -1);
      add(0, 0, 0, 0, 0, 3, 0, 1, -1);
      add(0, 0, 0, 0, 0, 4, 0, 1, -1);
      add(0, 0, 0, 0, 0, 5, 0, 1, -1);
      add(0, 0, 0, 0, 0, 5, 1, 0, -1);
      add(0, 0, 0, 0, 0, 5, 1, 0, -1);
      add(0, 0, 0, 0, 0, 0, 0, 0, -1);
      // go held low: exactly one run, then IDLE stays put until released.
      for (int i = 0; i <= int'(CMAX); i++) add(0, 1, 0, 0, 0, i, 0, 1, -1);
      add(0, 1, 0, 0, 0, 5, 1, 0, -1);
      add(0, 1, 0, 0, 0, 5, 1, 0, -1);
      add(0, 1, 0, 0, 0, 0, 0, 0, -1);
      add(0, 1, 0, 0, 0, 0, 0, 0, -1);
      add(0, 1, 0, 0, 0, 0, 0, 0, -1);
      add(0, 0, 0, 0, 0, 0, 0, 0, -1);

      // Reset held 3 clks.
      repeat (3) @(posedge clk);
      #1;
      check("reset count", 32'(bus.count), 0);
      check("reset done_sig", 32'(bus.done_sig), 0);
      check("reset busy", 32'(bus.busy), 0);
      rst_btn = 1'b1;

      // First tick lands on the 4th clk after release.
      bus.go_btn = 1'b0;
      @(posedge clk);
      #1;
      bus.go_btn = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("pre-tick busy", 32'(bus.busy), 0);
      @(posedge clk);
      #1;
      check("first tick busy", 32'(bus.busy), 1);
      check("first tick count", 32'(bus.count), 0);

      done_clks = 0;
      foreach (vt[i]) apply(vt[i]);

      // Press that lands exactly on the tick clk is accepted.
      bus.go_btn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bus.go_btn = 1'b0;
      @(posedge clk);
      #1;
      bus.go_btn = 1'b1;
      check("tick press busy", 32'(bus.busy), 1);
      check("tick press count", 32'(bus.count), 0);

      // Reset mid-run at count=2 aborts with no done pulse.
      vt.delete();
      add(0, 0, 0, 0, 0, 1, 0, 1, -1);
      add(0, 0, 0, 0, 0, 2, 0, 1, -1);
      foreach (vt[i]) apply(vt[i]);
      rst_btn = 1'b0;
      @(posedge clk);
      #1;
      rst_btn = 1'b1;
      check("midrun reset count", 32'(bus.count), 0);
      check("midrun reset busy", 32'(bus.busy), 0);
      check("midrun reset done_sig", 32'(bus.done_sig), 0);
      done_clks = 0;
      repeat (8) tick_period(0, 0, 0, 0, 0);
      check("post reset done_clks", done_clks, 0);
      check("post reset count", 32'(bus.count), 0);
      check("post reset busy", 32'(bus.busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
